fetch_unit: RTL and testbench

- Parametrised instruction-fetch front end for the RV32I core; the next generation of the single-cycle "iaddr <= iaddr+4 / branch target" PC logic.
- Issues pipelined requests to an IMEM with variable latency (req/gnt plus in-order rvalid) and buffers fetched words with their PCs in a prefetch FIFO.
- Presents them to the decoder over a valid/ready handshake and flushes on branch/jump redirect.

---
 rtl/fetch_unit.sv | 180 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch front end for the RV32I core. Issues pipelined requests
//   to an IMEM with variable latency (req/gnt, in-order rvalid). Fetched words
//   are stored with their PCs in a prefetch FIFO and handed to the decoder
//   over a valid/ready handshake. A redirect flushes the FIFO and restarts
//   fetching at the new PC. Responses to requests issued before the redirect
//   are counted and dropped as they return.
//
// Optional build macro: FETCH_PERF_EN adds the perf_* saturating counters.
//
// Ports
//   clk          clock, all state changes on posedge
//   reset        asynchronous active-high reset
//   imem_req     fetch request valid
//   imem_addr    fetch address (word aligned)
//   imem_gnt     request accepted this cycle
//   imem_rvalid  response valid (returns in grant order)
//   imem_rdata   response instruction word
//   instr_valid  FIFO head valid
//   instr_data   instruction at the FIFO head (0 when empty)
//   instr_pc     PC of the FIFO head (0 when empty)
//   instr_ready  decoder consumes the head
//   redirect     branch/jump taken: flush and refetch
//   redirect_pc  new fetch PC (low 2 bits ignored)
//   perf_fetched granted requests              (FETCH_PERF_EN only)
//   perf_flushed dropped responses + flushed entries (FETCH_PERF_EN only)
//   perf_stall   cycles with no instruction and no redirect (FETCH_PERF_EN only)
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int            AW        = 32,
    parameter int            DEPTH     = 4,
    parameter int            MAX_OUTST = 2,
    parameter logic [AW-1:0] RESET_VEC = '0
) (
    input  logic          clk,
    input  logic          reset,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [31:0]   imem_rdata,
    output logic          instr_valid,
    output logic [31:0]   instr_data,
    output logic [AW-1:0] instr_pc,
    input  logic          instr_ready,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]   perf_fetched,
    output logic [31:0]   perf_flushed,
    output logic [31:0]   perf_stall
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTST + 1);

    logic [AW-1:0] r_fetch_pc;
    logic [AW-1:0] r_resp_pc;
    logic [OW-1:0] r_outst;
    logic [OW-1:0] r_discard;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [AW-1:0] r_mem_pc   [DEPTH];
    logic [31:0]   r_mem_data [DEPTH];

    logic          w_grant;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic [OW-1:0] w_outst_after_resp;
    logic [AW-1:0] w_target;

    assign w_target = {redirect_pc[AW-1:2], 2'b00};

    // Space check counts words already buffered plus live (non-stale) requests
    // in flight, so the FIFO can never overflow. Gated by reset so the request
    // is low while reset is held.
    assign imem_req = !reset && !redirect
                    && (int'(r_outst) < MAX_OUTST)
                    && (int'(r_count) + int'(r_outst) - int'(r_discard) < DEPTH);
    assign imem_addr = r_fetch_pc;

    assign w_grant = imem_req && imem_gnt;
    // A response is stale if it belongs to a pre-redirect request, or if it
    // arrives in the very cycle of a redirect.
    assign w_drop  = imem_rvalid && (redirect || (r_discard != '0));
    assign w_push  = imem_rvalid && !w_drop;
    assign w_pop   = instr_valid && instr_ready && !redirect;
    assign w_outst_after_resp = r_outst - OW'(imem_rvalid);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_VEC;
            r_resp_pc  <= RESET_VEC;
            r_outst    <= '0;
            r_discard  <= '0;
            r_count    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            // No grant can coincide with a redirect, since the request is
            // suppressed in that cycle.
            r_outst <= w_outst_after_resp + OW'(w_grant);
            if (redirect) begin
                r_fetch_pc <= w_target;
                r_resp_pc  <= w_target;
                r_discard  <= w_outst_after_resp;
                r_count    <= '0;
                r_wptr     <= '0;
                r_rptr     <= '0;
            end else begin
                if (w_grant) begin
                    r_fetch_pc <= r_fetch_pc + AW'(4);
                end
                if (w_push) begin
                    r_resp_pc <= r_resp_pc + AW'(4);
                    r_wptr    <= r_wptr + PW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + PW'(1);
                end
                if (w_drop) begin
                    r_discard <= r_discard - OW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    // FIFO storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pc[r_wptr]   <= r_resp_pc;
            r_mem_data[r_wptr] <= imem_rdata;
        end
    end

    assign instr_valid = (r_count != '0);
    assign instr_data  = instr_valid ? r_mem_data[r_rptr] : '0;
    assign instr_pc    = instr_valid ? r_mem_pc[r_rptr]   : '0;

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_flushed;
    logic [31:0] r_perf_stall;
    logic [31:0] w_flush_inc;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

    // Entries still in the FIFO at a redirect count as flushed, including a
    // head that the decoder was accepting in that same cycle.
    assign w_flush_inc = (redirect ? 32'(r_count) : 32'd0) + 32'(w_drop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_perf_fetched <= '0;
            r_perf_flushed <= '0;
            r_perf_stall   <= '0;
        end else begin
            r_perf_fetched <= sat_add(r_perf_fetched, 32'(w_grant));
            r_perf_flushed <= sat_add(r_perf_flushed, w_flush_inc);
            r_perf_stall   <= sat_add(r_perf_stall, 32'(!instr_valid && !redirect));
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_flushed = r_perf_flushed;
    assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit. The bench owns an IMEM model that answers
//   each granted address with word_at(addr) after a chosen latency. Expected
//   behaviour is tracked at transaction level: a queue of in-flight requests
//   tagged stale when a redirect overtakes them, and a queue of instructions
//   the decoder should see next. Outputs are checked every cycle just before
//   the active edge; directed tests add literal expectations on top.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int          AW        = 32;
    localparam int          DEPTH     = 4;
    localparam int          MAX_OUTST = 2;
    localparam logic [31:0] RESET_VEC = 32'h0;

    logic          clk = 1'b0;
    logic          reset;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [31:0]   imem_rdata;
    logic          instr_valid;
    logic [31:0]   instr_data;
    logic [AW-1:0] instr_pc;
    logic          instr_ready;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
`ifdef FETCH_PERF_EN
    logic [31:0]   perf_fetched;
    logic [31:0]   perf_flushed;
    logic [31:0]   perf_stall;
`endif

    fetch_unit #(
        .AW        (AW),
        .DEPTH     (DEPTH),
        .MAX_OUTST (MAX_OUTST),
        .RESET_VEC (RESET_VEC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_flushed(perf_flushed),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } ins_t;

    req_t        pend[$];       // granted, not yet returned
    ins_t        m_fifo[$];     // instructions the decoder should see, in order
    logic [31:0] delivered[$];  // PCs consumed by the decoder in this test
    logic [31:0] m_fetch;       // next address the IMEM should be asked for
    int          cyc;
    int          lat;
    int          first_cyc;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive the IMEM response, compare outputs before the
    // edge, advance the model with the edge's events.
    task automatic tick();
        int   nonstale;
        bit   exp_req;
        bit   do_push;
        req_t r;
        ins_t e;
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_at(pend[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        @(negedge clk);
        nonstale = 0;
        foreach (pend[i]) if (!pend[i].stale) nonstale++;
        exp_req = !redirect && (pend.size() < MAX_OUTST) && (m_fifo.size() + nonstale < DEPTH);
        chk("imem_req", imem_req, exp_req);
        chk("imem_addr", imem_addr, m_fetch);
        chk("instr_valid", instr_valid, m_fifo.size() != 0);
        if (m_fifo.size() != 0) begin
            chk("instr_pc", instr_pc, m_fifo[0].pc);
            chk("instr_data", instr_data, m_fifo[0].data);
        end
        do_push = 1'b0;
        if (imem_rvalid) begin
            r = pend.pop_front();
            if (!r.stale && !redirect) begin
                e.pc    = r.addr;
                e.data  = word_at(r.addr);
                do_push = 1'b1;
            end
        end
        if (instr_valid && instr_ready && !redirect && m_fifo.size() != 0) begin
            delivered.push_back(m_fifo[0].pc);
            if (delivered.size() == 1) first_cyc = cyc;
            void'(m_fifo.pop_front());
        end
        if (do_push) m_fifo.push_back(e);
        if (imem_req && imem_gnt) begin
            pend.push_back('{addr: m_fetch, due: cyc + lat, stale: 1'b0});
            m_fetch = m_fetch + 32'd4;
        end
        if (redirect) begin
            m_fifo.delete();
            foreach (pend[i]) pend[i].stale = 1'b1;
            m_fetch = {redirect_pc[31:2], 2'b00};
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        pend.delete();
        m_fifo.delete();
        delivered.delete();
        m_fetch   = RESET_VEC;
        cyc       = 0;
        lat       = 1;
        first_cyc = -1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_addr", imem_addr, RESET_VEC);
        chk("rst_data", instr_data, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        reset = 1'b0;
        #1;
        chk("rel_addr", imem_addr, RESET_VEC);
`ifdef FETCH_PERF_EN
        chk("perf_fetched0", perf_fetched, 32'h0);
        chk("perf_flushed0", perf_flushed, 32'h0);
        chk("perf_stall0", perf_stall, 32'h0);
`endif
    endtask

    initial begin
        // Streaming: one instruction per cycle after a 3-cycle startup.
        do_reset();
        imem_gnt = 1'b1; instr_ready = 1'b1; lat = 1;
        repeat (12) tick();
        chk("t1_first_cycle", first_cyc, 2);
        chk("t1_count", delivered.size(), 10);
        for (int i = 0; i < 4; i++) chk("t1_pc", delivered[i], 32'(4 * i));

        // Backpressure: exactly DEPTH words buffered, then drain and resume.
        do_reset();
        imem_gnt = 1'b1; instr_ready = 1'b0; lat = 1;
        repeat (10) tick();
        chk("t2_req_full", imem_req, 1'b0);
        chk("t2_head_pc", instr_pc, 32'h0);
        chk("t2_valid", instr_valid, 1'b1);
        instr_ready = 1'b1;
        repeat (8) tick();
        for (int i = 0; i < 5; i++) chk("t2_pc", delivered[i], 32'(4 * i));

        // Grant withheld: address held, nothing fetched.
        do_reset();
        imem_gnt = 1'b0; instr_ready = 1'b1; lat = 1;
        repeat (3) begin
            tick();
            chk("t3_addr_hold", imem_addr, 32'h0);
            chk("t3_req", imem_req, 1'b1);
            chk("t3_valid", instr_valid, 1'b0);
        end
        imem_gnt = 1'b1;
        tick();
        chk("t3_addr_adv", imem_addr, 32'h4);
        lat = 2;
        for (int i = 0; i < 16; i++) begin
            imem_gnt    = (i % 3) != 0;
            instr_ready = (i % 4) != 1;
            tick();
        end

        // Redirect with two requests (8, 12) outstanding.
        do_reset();
        imem_gnt = 1'b1; instr_ready = 1'b0; lat = 1;
        tick(); tick();
        lat = 10;
        tick(); tick();
        chk("t4_req_sat", imem_req, 1'b0);
        chk("t4_valid", instr_valid, 1'b1);
        redirect = 1'b1; redirect_pc = 32'h103;
        tick();
        redirect = 1'b0;
        chk("t4_flushed", instr_valid, 1'b0);
        chk("t4_addr", imem_addr, 32'h100);
        instr_ready = 1'b1; lat = 1;
        repeat (20) tick();
        chk("t4_first_pc", delivered[0], 32'h100);
        chk("t4_second_pc", delivered[1], 32'h104);

        // Redirect in the same cycle as a response and a pop.
        do_reset();
        imem_gnt = 1'b1; instr_ready = 1'b1; lat = 1;
        tick(); tick();
        chk("t5_valid_pre", instr_valid, 1'b1);
        redirect = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        repeat (10) tick();
        chk("t5_first_pc", delivered[0], 32'h40);
        chk("t5_second_pc", delivered[1], 32'h44);

        // Asynchronous reset with 3 buffered and 1 outstanding.
        do_reset();
        imem_gnt = 1'b1; instr_ready = 1'b0; lat = 1;
        repeat (4) tick();
        chk("t6_valid", instr_valid, 1'b1);
        chk("t6_req_full", imem_req, 1'b0);
        chk("t6_head_pc", instr_pc, 32'h0);
        #2;
        reset = 1'b1;
        imem_rvalid = 1'b0;
        #1;
        chk("t6_async_valid", instr_valid, 1'b0);
        chk("t6_async_req", imem_req, 1'b0);
        chk("t6_async_pc", instr_pc, 32'h0);
        chk("t6_async_data", instr_data, 32'h0);
        chk("t6_async_addr", imem_addr, RESET_VEC);
        do_reset();
        imem_gnt = 1'b1; instr_ready = 1'b1;
        repeat (6) tick();
        chk("t6_restart_pc", delivered[0], RESET_VEC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
